// File: rtl/piso_shift_stream_if.sv
// piso_shift_stream_if
//   Word-side handshake and serial-side framing bundle for piso_shift_stream.
//   master : the word producer / serial consumer (drives in_data, in_valid, msb_first)
//   slave  : the converter (drives in_ready and the serial outputs)
//   Signals:
//     in_data      [DATA_WIDTH] parallel word
//     in_valid                  producer has a word
//     in_ready                  converter can accept a word this cycle
//     msb_first                 bit order for the word being accepted
//     serial_out                current serial bit
//     serial_valid              serial_out carries a data bit
//     last                      current bit is the final bit of the word
//     busy                      word in flight (same as serial_valid)
interface piso_shift_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  msb_first;
  logic                  serial_out;
  logic                  serial_valid;
  logic                  last;
  logic                  busy;

  modport master (
    output in_data, in_valid, msb_first,
    input  in_ready, serial_out, serial_valid, last, busy
  );

  modport slave (
    input  in_data, in_valid, msb_first,
    output in_ready, serial_out, serial_valid, last, busy
  );
endinterface

// File: rtl/piso_shift_stream.sv
// piso_shift_stream
//   Parallel-in / serial-out converter. Accepts DATA_WIDTH-bit words over a
//   valid/ready handshake and emits one bit per shift_en edge, MSB- or
//   LSB-first as chosen per word. Back-to-back words stream with no gap.
//   Ports:
//     clk       rising-edge clock
//     reset_n   asynchronous active-low reset
//     shift_en  advance to the next bit at this edge (ignored when idle)
//     abort     synchronous flush of the word in flight; blocks acceptance
//     s_if      slave side of piso_shift_stream_if (word in, serial out)
module piso_shift_stream #(
  parameter  int DATA_WIDTH = 8,
  localparam int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  shift_en,
  input  logic                  abort,
  piso_shift_stream_if.slave    s_if
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  state_t                state_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic                  order_reg;

  logic                  in_shift;
  logic                  last_bit;
  logic                  end_of_word;
  logic                  ready;
  logic                  accept;
  logic                  head_bit;
  logic [DATA_WIDTH-1:0] shift_next;

  assign in_shift    = (state_reg == SHIFT);
  assign last_bit    = in_shift && (bit_cnt_reg == LAST_IDX);
  assign end_of_word = last_bit && shift_en;

  // Ready is only offered when idle or on the edge that retires the final
  // bit, so a new word can chain without a gap. Held low during reset.
  assign ready  = reset_n && !abort && (!in_shift || end_of_word);
  assign accept = s_if.in_valid && ready;

  // The presented bit sits at the end of the register the shift moves toward.
  assign head_bit   = order_reg ? shift_reg[DATA_WIDTH-1] : shift_reg[0];
  assign shift_next = order_reg ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                                : {1'b0, shift_reg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      order_reg   <= 1'b0;
    end else if (abort) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      order_reg   <= 1'b0;
    end else if (accept) begin
      state_reg   <= SHIFT;
      shift_reg   <= s_if.in_data;
      bit_cnt_reg <= '0;
      order_reg   <= s_if.msb_first;
    end else if (in_shift && shift_en) begin
      shift_reg <= shift_next;
      if (last_bit) begin
        // Counter stays at the final index; it is only cleared by a load.
        state_reg <= IDLE;
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // All serial outputs decode straight from registered state, so the
  // asynchronous reset clears them immediately.
  assign s_if.in_ready     = ready;
  assign s_if.serial_valid = in_shift;
  assign s_if.busy         = in_shift;
  assign s_if.last         = last_bit;
  assign s_if.serial_out   = in_shift && head_bit;

endmodule
